// File: rtl/scan_pipe_reg_scan_dff.sv
// Single scannable flop: reset beats scan shift, which beats a gated functional load.
module scan_dff (
   input  logic CLK,
   input  logic RST,
   input  logic RV,
   input  logic SE,
   input  logic SI,
   input  logic LD,
   input  logic D,
   output logic Q
);

   always_ff @(posedge CLK) begin
      if (RST)
         Q <= RV;
      else if (SE)
         Q <= SI;
      else if (LD)
         Q <= D;
   end

endmodule

// File: rtl/scan_pipe_reg.sv
// Scannable pipeline register: DEPTH stages of WIDTH data bits plus a valid bit.
// Data flops load only behind a valid token; in scan mode all flops form one chain.
module scan_pipe_reg #(
   parameter int              WIDTH     = 8,
   parameter int              DEPTH     = 3,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             EN,
   input  logic             SE,
   input  logic             SI,
   input  logic [WIDTH-1:0] D,
   input  logic             VLD_IN,
   output logic [WIDTH-1:0] Q,
   output logic             VLD_OUT,
   output logic             SO
);

   localparam int SW = WIDTH + 1;
   localparam int L  = DEPTH * SW;

   if (WIDTH < 1 || DEPTH < 1) begin : g_param_check
      $error("scan_pipe_reg: WIDTH and DEPTH must both be >= 1");
   end

   // Flattened chain: stage s occupies [s*SW +: SW], data bits first, valid on top.
   logic [L-1:0] chain;

   for (genvar s = 0; s < DEPTH; s++) begin : g_stage
      logic             vprev;
      logic [WIDTH-1:0] dprev;

      if (s == 0) begin : g_first
         assign vprev = VLD_IN;
         assign dprev = D;
      end else begin : g_next
         assign vprev = chain[s*SW-1];
         assign dprev = chain[(s-1)*SW +: WIDTH];
      end

      for (genvar b = 0; b < WIDTH; b++) begin : g_bit
         logic sin;
         if (b == 0) begin : g_sin_head
            // Stage head is fed by the previous stage's valid flop, or SI for stage 0.
            if (s == 0) begin : g_si
               assign sin = SI;
            end else begin : g_vprev
               assign sin = vprev;
            end
         end else begin : g_sin_body
            assign sin = chain[s*SW+b-1];
         end

         scan_dff u_data (
            .CLK (CLK),
            .RST (RST),
            .RV  (RESET_VAL[b]),
            .SE  (SE),
            .SI  (sin),
            .LD  (EN & vprev),
            .D   (dprev[b]),
            .Q   (chain[s*SW+b])
         );
      end

      scan_dff u_vld (
         .CLK (CLK),
         .RST (RST),
         .RV  (1'b0),
         .SE  (SE),
         .SI  (chain[s*SW+WIDTH-1]),
         .LD  (EN),
         .D   (vprev),
         .Q   (chain[s*SW+WIDTH])
      );
   end

   assign Q       = chain[(DEPTH-1)*SW +: WIDTH];
   assign VLD_OUT = chain[L-1];
   assign SO      = chain[L-1];

endmodule

// File: tb/tb_scan_pipe_reg.sv
// Scoreboard bench for scan_pipe_reg (WIDTH=8, DEPTH=3, RESET_VAL=8'hA5).
module tb_scan_pipe_reg;

   logic       CLK = 1'b0;
   logic       RST, EN, SE, SI, VLD_IN;
   logic [7:0] D;
   logic [7:0] Q;
   logic       VLD_OUT, SO;

   scan_pipe_reg #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'hA5)) dut (
      .CLK     (CLK),
      .RST     (RST),
      .EN      (EN),
      .SE      (SE),
      .SI      (SI),
      .D       (D),
      .VLD_IN  (VLD_IN),
      .Q       (Q),
      .VLD_OUT (VLD_OUT),
      .SO      (SO)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int         edge_n;
      logic [7:0] q;
      logic       vld;
      logic       so;
      bit         chk_q;
      string      name;
   } exp_t;

   exp_t exp_q[$];
   int   ed     = 0;
   int   checks = 0;
   int   errors = 0;

   function automatic void push_exp(int n, logic [7:0] q, logic v, logic s, bit cq, string nm);
      exp_t e;
      e.edge_n = n; e.q = q; e.vld = v; e.so = s; e.chk_q = cq; e.name = nm;
      exp_q.push_back(e);
   endfunction

   task automatic step();
      @(posedge CLK);
      ed++;
      #1;
   endtask

   // Monitor: compare every expectation scheduled for the edge just taken.
   always @(negedge CLK) begin
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
         if (exp_q[i].edge_n == ed) begin
            if (exp_q[i].chk_q) begin
               checks++;
               if (Q !== exp_q[i].q) begin
                  errors++;
                  $display("FAIL %s edge %0d Q got %h want %h", exp_q[i].name, ed, Q, exp_q[i].q);
               end
            end
            checks++;
            if (VLD_OUT !== exp_q[i].vld) begin
               errors++;
               $display("FAIL %s edge %0d VLD_OUT got %b want %b", exp_q[i].name, ed, VLD_OUT, exp_q[i].vld);
            end
            checks++;
            if (SO !== exp_q[i].so) begin
               errors++;
               $display("FAIL %s edge %0d SO got %b want %b", exp_q[i].name, ed, SO, exp_q[i].so);
            end
            exp_q.delete(i);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout edge %0d got running want finished", ed);
      $fatal(1, "timeout");
   end

   logic [26:0] pat;
   logic [26:0] old_img;
   logic [26:0] rst_img;
   logic [7:0]  qpat;
   int          base;

   task automatic preload(string nm);
      base = ed;
      push_exp(base+1, 8'hA5, 1'b0, 1'b0, 1'b1, nm);
      push_exp(base+2, 8'hA5, 1'b0, 1'b0, 1'b1, nm);
      push_exp(base+3, 8'h11, 1'b1, 1'b1, 1'b1, nm);
      RST = 1'b0; SE = 1'b0; EN = 1'b1; VLD_IN = 1'b1;
      D = 8'h11; step();
      D = 8'h22; step();
      D = 8'h33; step();
   endtask

   task automatic reset_edge(string nm);
      RST = 1'b1;
      push_exp(ed+1, 8'hA5, 1'b0, 1'b0, 1'b1, nm);
      step();
      RST = 1'b0;
   endtask

   initial begin
      pat     = 27'h5A5A5A5;
      old_img = {1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 8'h33};
      rst_img = {1'b0, 8'hA5, 1'b0, 8'hA5, 1'b0, 8'hA5};
      for (int b = 0; b < 8; b++) qpat[b] = pat[8-b];

      // 1: reset ignores D/VLD_IN
      RST = 1'b1; EN = 1'b1; SE = 1'b0; SI = 1'b1; D = 8'hFF; VLD_IN = 1'b1;
      push_exp(1, 8'hA5, 1'b0, 1'b0, 1'b1, "reset");
      push_exp(2, 8'hA5, 1'b0, 1'b0, 1'b1, "reset");
      step(); step();

      // 2: three tokens, latency DEPTH-1 edges after sampling
      base = ed;
      push_exp(base+1, 8'hA5, 1'b0, 1'b0, 1'b1, "stream");
      push_exp(base+2, 8'hA5, 1'b0, 1'b0, 1'b1, "stream");
      push_exp(base+3, 8'h11, 1'b1, 1'b1, 1'b1, "stream");
      push_exp(base+4, 8'h22, 1'b1, 1'b1, 1'b1, "stream");
      push_exp(base+5, 8'h33, 1'b1, 1'b1, 1'b1, "stream");
      push_exp(base+6, 8'h33, 1'b0, 1'b0, 1'b1, "stream_bubble");
      RST = 1'b0; EN = 1'b1; VLD_IN = 1'b1;
      D = 8'h11; step();
      D = 8'h22; step();
      D = 8'h33; step();
      VLD_IN = 1'b0; D = 8'h00;
      step(); step(); step();

      // 3: stall freezes, resume yields 22 never 77
      reset_edge("reset3");
      base = ed;
      push_exp(base+1, 8'hA5, 1'b0, 1'b0, 1'b1, "stall");
      push_exp(base+2, 8'hA5, 1'b0, 1'b0, 1'b1, "stall");
      push_exp(base+3, 8'h11, 1'b1, 1'b1, 1'b1, "stall");
      push_exp(base+4, 8'h11, 1'b1, 1'b1, 1'b1, "stall_hold");
      push_exp(base+5, 8'h11, 1'b1, 1'b1, 1'b1, "stall_hold");
      push_exp(base+6, 8'h22, 1'b1, 1'b1, 1'b1, "stall_resume");
      push_exp(base+7, 8'h22, 1'b0, 1'b0, 1'b1, "stall_resume");
      push_exp(base+8, 8'h22, 1'b0, 1'b0, 1'b1, "stall_resume");
      EN = 1'b1; VLD_IN = 1'b1;
      D = 8'h11; step();
      D = 8'h22; step();
      D = 8'h00; VLD_IN = 1'b0; step();
      EN = 1'b0; D = 8'h77; VLD_IN = 1'b1; step(); step();
      EN = 1'b1; VLD_IN = 1'b0; step(); step(); step();

      // 4: bubble keeps last valid data on Q
      base = ed;
      push_exp(base+1, 8'h22, 1'b0, 1'b0, 1'b1, "bubble");
      push_exp(base+2, 8'h22, 1'b0, 1'b0, 1'b1, "bubble");
      push_exp(base+3, 8'h3C, 1'b1, 1'b1, 1'b1, "bubble");
      push_exp(base+4, 8'h3C, 1'b0, 1'b0, 1'b1, "bubble_hold");
      push_exp(base+5, 8'h3C, 1'b0, 1'b0, 1'b1, "bubble_hold");
      push_exp(base+6, 8'h3C, 1'b0, 1'b0, 1'b1, "bubble_hold");
      D = 8'h3C; VLD_IN = 1'b1; step();
      D = 8'hFF; VLD_IN = 1'b0;
      for (int i = 0; i < 5; i++) step();

      // 5: scan unload then reload, then pattern reappears on SO
      reset_edge("reset5");
      preload("preload5");
      base = ed;
      SE = 1'b1; EN = 1'b0;
      for (int k = 1; k <= 54; k++) begin
         logic s;
         s = (k < 27) ? old_img[26-k] : pat[(k-27) % 27];
         push_exp(base+k, qpat, s, s, (k == 27 || k == 54), "scan");
         SI = pat[(k-1) % 27];
         step();
      end

      // 6: reset mid-scan clears everything, SE still high afterwards
      SE = 1'b0;
      reset_edge("reset6");
      preload("preload6");
      base = ed;
      SE = 1'b1; EN = 1'b0;
      for (int k = 1; k <= 19; k++) begin
         logic s;
         if (k < 10) s = old_img[26-k];
         else if (k == 10) s = 1'b0;
         else s = rst_img[26-(k-10)];
         push_exp(base+k, 8'hA5, s, s, (k == 10), "scan_rst");
         RST = (k == 10);
         SI  = pat[k-1];
         step();
      end
      RST = 1'b0; SE = 1'b0;
      step(); step();

      if (exp_q.size() != 0) begin
         errors += exp_q.size();
         $display("FAIL pending got %0d unchecked want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
